// File: rtl/uart_axis_pkg.sv
// uart_axis_pkg
//   Shared definitions for the UART receive-side stream logic.
//   UART_DATA_WIDTH : width of one UART character on the stream
//   ptr_w()         : width of a FIFO pointer that carries an extra wrap bit
//   uart_rx_status_t: status bundle for the CSR block. The field widths match
//                     the default FIFO parameters (DEPTH=16, CNT_WIDTH=8).
package uart_axis_pkg;

  localparam int UART_DATA_WIDTH = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [4:0] level;
    logic       almost_full;
    logic       overflow;
    logic [7:0] drop_cnt;
  } uart_rx_status_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram
//   Simple dual-port storage for the receive FIFO.
//   Writes are synchronous. Reads are asynchronous. The array is not reset.
//   clk        : system clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write index
//   i_wr_data  : write data
//   i_rd_addr  : read index
//   o_rd_data  : combinational read data
module uart_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Elastic buffer placed after the UART receiver. The receiver pulses tvalid
//   for one cycle per byte and ignores tready. Every byte that fits is stored.
//   Bytes that arrive while the buffer is full are dropped and counted. The
//   stored bytes are presented on a fully compliant AXI-Stream master port.
//   clk, rst_n     : clock and asynchronous active-low reset
//   s_axis_*       : byte stream from the receiver (tready = !full, informational only)
//   m_axis_*       : byte stream to the consumer (tvalid = !empty)
//   level          : occupancy, 0..DEPTH
//   almost_full    : level >= AFULL_THRESH
//   overflow       : sticky flag, set when any byte has been dropped
//   overflow_clr   : clears overflow and drop_cnt. A drop in the same cycle takes priority.
//   drop_cnt       : saturating count of dropped bytes
module uart_rx_fifo
  import uart_axis_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_drop_cnt;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic [PW-1:0]        w_level;

  // The pointers are equal when the buffer is empty. When it is full, the
  // indices match and the wrap bits differ.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Full is judged from registered state only. A pop in the same cycle does
  // not make room for an incoming byte.
  assign w_push  = s_axis_tvalid && !w_full;
  assign w_drop  = s_axis_tvalid &&  w_full;
  assign w_pop   = !w_empty && m_axis_tready;

  assign w_level = r_wr_ptr - r_rd_ptr;

  uart_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (s_axis_tdata),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (m_axis_tdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Set has priority over clear. When both occur in the same cycle, the
  // count restarts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (overflow_clr)
        r_drop_cnt <= CNT_WIDTH'(1);
      else if (r_drop_cnt != {CNT_WIDTH{1'b1}})
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign s_axis_tready = !w_full;
  assign m_axis_tvalid = !w_empty;
  assign level         = w_level;
  assign almost_full   = (w_level >= PW'(AFULL_THRESH));
  assign overflow      = r_overflow;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(12), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .level(level), .almost_full(almost_full), .overflow(overflow),
    .overflow_clr(overflow_clr), .drop_cnt(drop_cnt)
  );

  // Advance one clock. Outputs are sampled and inputs are driven 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load 16 bytes base..base+15 with no checking.
  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 8'(i);
      step();
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid); end
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready: got %0b expected 1", s_axis_tready); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull: got %0b expected 0", almost_full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5;
    step();
    s_axis_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL single_tvalid: got %0b expected 1", m_axis_tvalid); end
    checks++; if (level !== 5'd1) begin failures++; $display("FAIL single_level: got %0d expected 1", level); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA5) begin failures++; $display("FAIL single_stall%0d: got valid=%0b data=%0h expected valid=1 data=a5", i, m_axis_tvalid, m_axis_tdata); end
    end
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0) begin failures++; $display("FAIL single_pop: got valid=%0b level=%0d expected valid=0 level=0", m_axis_tvalid, level); end
  endtask

  task automatic test_fill_drain();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(i);
      step();
      checks++; if (level !== 5'(i + 1)) begin failures++; $display("FAIL fill_level%0d: got %0d expected %0d", i, level, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 12)) begin failures++; $display("FAIL fill_afull%0d: got %0b expected %0b", i, almost_full, (i + 1 >= 12)); end
    end
    s_axis_tvalid = 1'b0;
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL full_s_tready: got %0b expected 0", s_axis_tready); end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'(i)) begin failures++; $display("FAIL drain%0d: got valid=%0b data=%0h expected valid=1 data=%0h", i, m_axis_tvalid, m_axis_tdata, i); end
      step();
    end
    m_axis_tready = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0) begin failures++; $display("FAIL drain_empty: got valid=%0b level=%0d expected valid=0 level=0", m_axis_tvalid, level); end
  endtask

  task automatic test_overflow();
    m_axis_tready = 1'b0;
    fill(8'h40);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55; step();
    s_axis_tdata = 8'h66; step();
    s_axis_tvalid = 1'b0;
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin failures++; $display("FAIL drop_two: got ovf=%0b cnt=%0d expected ovf=1 cnt=2", overflow, drop_cnt); end
    checks++; if (level !== 5'd16 || m_axis_tdata !== 8'h40) begin failures++; $display("FAIL drop_unstored: got level=%0d head=%0h expected level=16 head=40", level, m_axis_tdata); end
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL clr: got ovf=%0b cnt=%0d expected ovf=0 cnt=0", overflow, drop_cnt); end
    overflow_clr = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 8'h99; step();
    overflow_clr = 1'b0; s_axis_tvalid = 1'b0;
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin failures++; $display("FAIL clr_vs_drop: got ovf=%0b cnt=%0d expected ovf=1 cnt=1", overflow, drop_cnt); end
    // Full buffer with a pop and an incoming byte in the same cycle: the pop
    // happens and the byte is still dropped.
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h77; m_axis_tready = 1'b1; step();
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    checks++; if (level !== 5'd15 || drop_cnt !== 8'd2) begin failures++; $display("FAIL full_pop_drop: got level=%0d cnt=%0d expected level=15 cnt=2", level, drop_cnt); end
    m_axis_tready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      checks++; if (m_axis_tdata !== 8'h40 + 8'(i)) begin failures++; $display("FAIL ovf_drain%0d: got %0h expected %0h", i, m_axis_tdata, 8'h40 + 8'(i)); end
      step();
    end
    m_axis_tready = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL ovf_drain_empty: got valid=%0b expected 0", m_axis_tvalid); end
  endtask

  task automatic test_back_to_back();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'h80 + 8'(i); step();
    end
    for (int k = 0; k < 40; k++) begin
      checks++; if (m_axis_tdata !== 8'h80 + 8'(k)) begin failures++; $display("FAIL b2b_data%0d: got %0h expected %0h", k, m_axis_tdata, 8'h80 + 8'(k)); end
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'h88 + 8'(k); m_axis_tready = 1'b1;
      step();
      checks++; if (level !== 5'd8) begin failures++; $display("FAIL b2b_level%0d: got %0d expected 8", k, level); end
    end
    s_axis_tvalid = 1'b0;
    for (int k = 40; k < 48; k++) begin
      checks++; if (m_axis_tdata !== 8'h80 + 8'(k)) begin failures++; $display("FAIL b2b_tail%0d: got %0h expected %0h", k, m_axis_tdata, 8'h80 + 8'(k)); end
      step();
    end
    m_axis_tready = 1'b0;
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL b2b_empty: got level=%0d expected 0", level); end
  endtask

  task automatic test_async_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'h30 + 8'(i); step();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1; step();
    checks++; if (level !== 5'd7 || m_axis_tdata !== 8'h31) begin failures++; $display("FAIL arst_pre: got level=%0d head=%0h expected level=7 head=31", level, m_axis_tdata); end
    // Assert reset between clock edges. The outputs must clear without a clock.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0 || s_axis_tready !== 1'b1) begin failures++; $display("FAIL arst_async: got valid=%0b level=%0d s_tready=%0b expected 0 0 1", m_axis_tvalid, level, s_axis_tready); end
    m_axis_tready = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL arst_idle: got valid=%0b expected 0", m_axis_tvalid); end
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hE1; step();
    s_axis_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hE1 || level !== 5'd1) begin failures++; $display("FAIL arst_new: got valid=%0b data=%0h level=%0d expected 1 e1 1", m_axis_tvalid, m_axis_tdata, level); end
    m_axis_tready = 1'b1; step(); m_axis_tready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int sent = 0, delivered = 0, drops = 0;
    logic v, r, full;
    logic [7:0] d;
    int bad = 0;
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if ((m_axis_tvalid !== (q.size() != 0)) || (q.size() != 0 && m_axis_tdata !== q[0])) begin
        bad++;
        if (bad <= 5) $display("FAIL rand_head%0d: got valid=%0b data=%0h expected valid=%0b data=%0h", n, m_axis_tvalid, m_axis_tdata, q.size() != 0, (q.size() != 0) ? q[0] : 8'h00);
      end
      v = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) == 0);
      d = 8'($urandom);
      s_axis_tvalid = v; s_axis_tdata = d; m_axis_tready = r;
      full = (q.size() == 16);
      if (r && q.size() != 0) begin void'(q.pop_front()); delivered++; end
      if (v) begin
        sent++;
        if (full) drops++;
        else q.push_back(d);
      end
      step();
    end
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    while (q.size() != 0) begin
      if (m_axis_tdata !== q[0]) begin
        bad++;
        if (bad <= 5) $display("FAIL rand_tail: got %0h expected %0h", m_axis_tdata, q[0]);
      end
      void'(q.pop_front()); delivered++;
      step();
    end
    m_axis_tready = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_order: got %0d bad beats expected 0", bad); end
    checks++; if (drop_cnt !== ((drops > 255) ? 8'd255 : 8'(drops))) begin failures++; $display("FAIL rand_drop_cnt: got %0d expected %0d", drop_cnt, (drops > 255) ? 255 : drops); end
    checks++; if (overflow !== (drops > 0)) begin failures++; $display("FAIL rand_overflow: got %0b expected %0b", overflow, drops > 0); end
    checks++; if (m_axis_tvalid !== 1'b0 || level !== 5'd0) begin failures++; $display("FAIL rand_empty: got valid=%0b level=%0d expected 0 0 (sent=%0d delivered=%0d)", m_axis_tvalid, level, sent, delivered); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
